// File: rtl/sfp_status_led.sv
// Per-channel SFP link/activity status engine driving the board status LEDs.
// Each channel runs a small link FSM; a shared tick divider feeds activity
// stretch, flap hold and the slow/fast blink phases.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_DOWN    | link down and hold window expired, LED off
//   ST_UP_IDLE | link up, no recent traffic, LED steady on
//   ST_UP_ACT  | link up, traffic seen within the stretch window, LED fast blink
//   ST_FLAP    | link just dropped, hold window running, LED slow blink

module sfp_status_led #(
    parameter int SFP_COUNT     = 2,
    parameter int LED_COUNT     = 4,
    parameter int TICK_DIV      = 100000,
    parameter int STRETCH_TICKS = 50,
    parameter int BLINK_TICKS   = 250,
    parameter int HOLD_TICKS    = 1000,
    parameter int DROP_CNT_W    = 8
) (
    input  logic                            sysclk_100m,
    input  logic                            sys_reset_n,
    input  logic [SFP_COUNT-1:0]            link_up,
    input  logic [SFP_COUNT-1:0]            rx_act,
    input  logic [SFP_COUNT-1:0]            tx_act,
    input  logic [1:0]                      led_mode,
    input  logic                            clr_drop,
    output logic [LED_COUNT-1:0]            sleds,
    output logic                            any_link_up,
    output logic [SFP_COUNT*DROP_CNT_W-1:0] link_drop_cnt
);

    localparam int TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FAST_TICKS = (BLINK_TICKS / 4 > 1) ? BLINK_TICKS / 4 : 1;
    localparam int BLINK_W    = $clog2(BLINK_TICKS + 1);
    localparam int TMR_MAX    = (STRETCH_TICKS > HOLD_TICKS) ? STRETCH_TICKS : HOLD_TICKS;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);
    localparam int LED_CH     = (SFP_COUNT < LED_COUNT) ? SFP_COUNT : LED_COUNT;

    typedef enum logic [1:0] {
        ST_DOWN    = 2'd0,
        ST_UP_IDLE = 2'd1,
        ST_UP_ACT  = 2'd2,
        ST_FLAP    = 2'd3
    } ch_state_t;

    logic [TICK_W-1:0]     tick_cnt_q;
    logic                  tick;
    logic [BLINK_W-1:0]    slow_cnt_q;
    logic [BLINK_W-1:0]    fast_cnt_q;
    logic                  slow_q;
    logic                  fast_q;

    logic [SFP_COUNT-1:0]  sync_q;
    logic [SFP_COUNT-1:0]  lu_s_q;
    logic [SFP_COUNT-1:0]  lu_prev_q;
    logic [SFP_COUNT-1:0]  drop;
    logic [SFP_COUNT-1:0]  act;

    ch_state_t             state_q    [SFP_COUNT];
    logic [TMR_W-1:0]      tmr_q      [SFP_COUNT];
    logic [DROP_CNT_W-1:0] drop_cnt_q [SFP_COUNT];

    logic                  alarm;
    logic [LED_COUNT-1:0]  sleds_d;
    logic [LED_COUNT-1:0]  sleds_q;
    logic                  any_q;

    assign tick = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign act  = rx_act | tx_act;
    assign drop = lu_prev_q & ~lu_s_q;

    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            tick_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            slow_cnt_q <= '0;
            fast_cnt_q <= '0;
            slow_q     <= 1'b0;
            fast_q     <= 1'b0;
        end else if (tick) begin
            if (slow_cnt_q == BLINK_W'(BLINK_TICKS - 1)) begin
                slow_cnt_q <= '0;
                slow_q     <= ~slow_q;
            end else begin
                slow_cnt_q <= slow_cnt_q + BLINK_W'(1);
            end
            if (fast_cnt_q == BLINK_W'(FAST_TICKS - 1)) begin
                fast_cnt_q <= '0;
                fast_q     <= ~fast_q;
            end else begin
                fast_cnt_q <= fast_cnt_q + BLINK_W'(1);
            end
        end
    end

    // lu_prev_q resets low so a channel that comes out of reset down never
    // registers a phantom drop.
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sync_q    <= '0;
            lu_s_q    <= '0;
            lu_prev_q <= '0;
        end else begin
            sync_q    <= link_up;
            lu_s_q    <= sync_q;
            lu_prev_q <= lu_s_q;
        end
    end

    // One timer per channel serves as stretch counter in ST_UP_ACT and as
    // hold counter in ST_FLAP; the two are never live at once.
    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < SFP_COUNT; i++) begin
                state_q[i] <= ST_DOWN;
                tmr_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < SFP_COUNT; i++) begin
                case (state_q[i])
                    ST_DOWN: begin
                        if (lu_s_q[i]) begin
                            state_q[i] <= ST_UP_IDLE;
                        end
                    end
                    ST_UP_IDLE: begin
                        if (!lu_s_q[i]) begin
                            state_q[i] <= ST_FLAP;
                            tmr_q[i]   <= TMR_W'(HOLD_TICKS);
                        end else if (act[i]) begin
                            state_q[i] <= ST_UP_ACT;
                            tmr_q[i]   <= TMR_W'(STRETCH_TICKS);
                        end
                    end
                    ST_UP_ACT: begin
                        if (!lu_s_q[i]) begin
                            state_q[i] <= ST_FLAP;
                            tmr_q[i]   <= TMR_W'(HOLD_TICKS);
                        end else if (act[i]) begin
                            tmr_q[i]   <= TMR_W'(STRETCH_TICKS);
                        end else if (tick) begin
                            if (tmr_q[i] <= TMR_W'(1)) begin
                                state_q[i] <= ST_UP_IDLE;
                                tmr_q[i]   <= '0;
                            end else begin
                                tmr_q[i]   <= tmr_q[i] - TMR_W'(1);
                            end
                        end
                    end
                    ST_FLAP: begin
                        if (lu_s_q[i]) begin
                            state_q[i] <= ST_UP_IDLE;
                            tmr_q[i]   <= '0;
                        end else if (tick) begin
                            if (tmr_q[i] <= TMR_W'(1)) begin
                                state_q[i] <= ST_DOWN;
                                tmr_q[i]   <= '0;
                            end else begin
                                tmr_q[i]   <= tmr_q[i] - TMR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q[i] <= ST_DOWN;
                        tmr_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < SFP_COUNT; i++) begin
                drop_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SFP_COUNT; i++) begin
                if (clr_drop) begin
                    drop_cnt_q[i] <= drop[i] ? DROP_CNT_W'(1) : '0;
                end else if (drop[i] && (drop_cnt_q[i] != '1)) begin
                    drop_cnt_q[i] <= drop_cnt_q[i] + DROP_CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        alarm = 1'b0;
        for (int i = 0; i < SFP_COUNT; i++) begin
            if ((state_q[i] == ST_DOWN) || (state_q[i] == ST_FLAP)) begin
                alarm = 1'b1;
            end
        end
    end

    always_comb begin
        sleds_d = '0;
        case (led_mode)
            2'd0: begin
                for (int i = 0; i < LED_CH; i++) begin
                    case (state_q[i])
                        ST_UP_IDLE: sleds_d[i] = 1'b1;
                        ST_UP_ACT:  sleds_d[i] = fast_q;
                        ST_FLAP:    sleds_d[i] = slow_q;
                        default:    sleds_d[i] = 1'b0;
                    endcase
                end
                // Spare top LED doubles as a heartbeat.
                if (LED_COUNT > SFP_COUNT) begin
                    sleds_d[LED_COUNT-1] = slow_q;
                end
            end
            2'd1:    sleds_d = alarm ? {LED_COUNT{slow_q}} : {LED_COUNT{1'b1}};
            2'd2:    sleds_d = {LED_COUNT{1'b1}};
            default: sleds_d = '0;
        endcase
    end

    always_ff @(posedge sysclk_100m or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sleds_q <= '0;
            any_q   <= 1'b0;
        end else begin
            sleds_q <= sleds_d;
            any_q   <= |lu_s_q;
        end
    end

    assign sleds       = sleds_q;
    assign any_link_up = any_q;

    for (genvar g = 0; g < SFP_COUNT; g++) begin : g_drop_cnt
        assign link_drop_cnt[g*DROP_CNT_W +: DROP_CNT_W] = drop_cnt_q[g];
    end

endmodule

// File: doc/sfp_status_led.md
Name: sfp_status_led

Overview:
- Per-channel SFP link/activity status engine that drives the board status LEDs.
- Generalised successor to the fixed per-board LED wiring: SFP_COUNT channels, LED_COUNT LEDs, selectable display mode, per-channel link-drop counters.
- Sits beside the PCS/PMA test core in the sysclk_100m domain. It consumes link-up levels and rx/tx activity pulses and drives sleds.

Parameters:
- SFP_COUNT, 2, number of SFP channels (1..8).
- LED_COUNT, 4, number of LEDs driven.
- TICK_DIV, 100000, sysclk cycles per tick (1 ms at 100 MHz).
- STRETCH_TICKS, 50, activity stretch length in ticks.
- BLINK_TICKS, 250, slow-blink half-period in ticks. Fast half-period is max(BLINK_TICKS/4, 1).
- HOLD_TICKS, 1000, FLAP state duration in ticks after a link drop.
- DROP_CNT_W, 8, width of each link-drop counter.

Ports:
- sysclk_100m  in  1  system clock.
- sys_reset_n  in  1  asynchronous active-low reset.
- link_up  in  SFP_COUNT  per-channel link status, asynchronous, synchronised internally.
- rx_act  in  SFP_COUNT  one-cycle rx-frame pulses, sysclk_100m domain.
- tx_act  in  SFP_COUNT  one-cycle tx-frame pulses, sysclk_100m domain.
- led_mode  in  2  0 = status, 1 = alarm, 2 = lamp test, 3 = dark.
- clr_drop  in  1  one-cycle pulse, clears all drop counters.
- sleds  out  LED_COUNT  registered LED drive, active-high.
- any_link_up  out  1  OR of synchronised link_up, registered.
- link_drop_cnt  out  SFP_COUNT*DROP_CNT_W  per-channel saturating drop counters. Channel i occupies bits [i*DROP_CNT_W +: DROP_CNT_W].

Behaviour:
- Reset (async assert, sync release at sysclk_100m) clears all registers:
  - sleds = 0, any_link_up = 0, link_drop_cnt = 0.
  - All channels in DOWN. Tick counter, blink phases and stretch/hold counters = 0.
- Tick: free-running counter 0..TICK_DIV-1. tick = 1 for one cycle when the counter wraps. The first tick occurs TICK_DIV cycles after reset release.
- Slow phase toggles every BLINK_TICKS ticks. Fast phase toggles every max(BLINK_TICKS/4, 1) ticks. Both start at 0.
- link_up passes through a 2-flop synchroniser per channel to give lu_s. A falling edge of lu_s is a drop event.
- Per-channel FSM (states DOWN, UP_IDLE, UP_ACT, FLAP):
  - DOWN: lu_s=1 -> UP_IDLE.
  - UP_IDLE: lu_s=0 -> FLAP, hold counter loaded with HOLD_TICKS. Activity pulse (rx_act|tx_act) -> UP_ACT, stretch counter loaded with STRETCH_TICKS.
  - UP_ACT: lu_s=0 -> FLAP (drop has priority over activity). Activity pulse reloads STRETCH_TICKS. Stretch counter decrements on tick; reaching 0 -> UP_IDLE.
  - FLAP: lu_s=1 -> UP_IDLE. Hold counter decrements on tick; reaching 0 -> DOWN.
  - Activity pulses in DOWN or FLAP are ignored.
- Latency: a link_up change that is stable before edge N updates the FSM at edge N+2 and sleds at edge N+3.
- Drop counter, per channel:
  - +1 on each drop event; saturates at all-ones.
  - clr_drop zeroes all counters.
  - clr_drop coincident with a drop on a channel: that channel's counter = 1.
- Status mode (0):
  - sleds[i] for i < min(SFP_COUNT, LED_COUNT): DOWN -> 0, UP_IDLE -> 1, UP_ACT -> fast phase, FLAP -> slow phase.
  - If LED_COUNT > SFP_COUNT: sleds[LED_COUNT-1] = slow phase (heartbeat). All other unused LEDs = 0.
- Alarm mode (1): all sleds = slow phase if any channel is DOWN or FLAP; otherwise all sleds = 1.
- Lamp test mode (2): all 1. Dark mode (3): all 0.
- Channel FSMs and counters keep running in every mode. A led_mode change takes effect on the next edge.
- any_link_up = registered OR of lu_s.

Test Plan:
(All scenarios use TICK_DIV=4, STRETCH_TICKS=3, BLINK_TICKS=2, HOLD_TICKS=5, SFP_COUNT=2, LED_COUNT=4, led_mode=0.)
- Reset release, all link_up=0 -> sleds=4'b0000. From the first slow toggle (8 cycles after reset release) sleds[3] toggles every 8 cycles. link_drop_cnt=0.
- link_up[0] 0->1, stable before edge N -> sleds[0]=1 at edge N+3, any_link_up=1, sleds[1]=0.
- Channel 0 up, one rx_act[0] pulse -> sleds[0] follows fast phase (4-cycle half-period) for 3 ticks, then returns to 1. A second pulse mid-stretch extends to 3 ticks from that pulse.
- Channel 0 up then link_up[0]=0 -> drop count 0->1, sleds[0] blinks slow for 5 ticks, then 0. Relinking during hold -> UP_IDLE (sleds[0]=1), count stays 1.
- 256 drops on channel 1 -> count saturates at 8'hFF. clr_drop coincident with the 257th drop -> count = 1.
- Channel 1 down, led_mode=1 -> all sleds follow slow phase. led_mode=2 -> 4'b1111 next edge. Assert sys_reset_n low mid-blink -> all outputs 0 immediately without a clock edge.
